// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared constants and types for the PS/2 keyboard receive path.
//   PS2_FRAME_BITS : bits per PS/2 frame (start + 8 data + parity + stop)
//   PS2_BREAK      : break prefix scan code
//   PS2_EXT        : extended-key prefix scan code
//   trackState_e   : make/break tracker state
// Optional macro used by the receive path: PS2_TIMEOUT_EN.
// ---------------------------------------------------------------------------
package ps2_pkg;

  localparam int PS2_FRAME_BITS = 11;
  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT = 8'hE0;

  typedef enum logic {
    IDLE  = 1'b0,
    BREAK = 1'b1
  } trackState_e;

endpackage

// File: rtl/ps2_fifo.sv
// ---------------------------------------------------------------------------
// ps2_fifo
// Show-ahead FIFO of FIFO_DEPTH x 8-bit scan codes.
// FIFO_DEPTH must be a power of two, at least 2; the pointers wrap
// naturally at their full width.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   push_i     : write wdata_i (dropped when full, even if popping)
//   pop_i      : drop the head entry (ignored when empty)
//   wdata_i    : scan code to write
//   rdata_o    : current head entry, combinational
//   full_o     : FIFO holds FIFO_DEPTH entries
//   count_o    : number of stored entries
// ---------------------------------------------------------------------------
module ps2_fifo #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push_i,
  input  logic                        pop_i,
  input  logic [7:0]                  wdata_i,
  output logic [7:0]                  rdata_o,
  output logic                        full_o,
  output logic [$clog2(FIFO_DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = 1;
  localparam logic [PTR_W:0] CNT_ONE = 1;
  localparam logic [PTR_W:0] CNT_FULL = FIFO_DEPTH;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr_q;
  logic [PTR_W-1:0] rptr_q;
  logic [PTR_W:0]   count_q;
  logic             doPush;
  logic             doPop;

  // Fullness is judged on the current count, so a pop in the same cycle
  // does not make room for a push.
  assign full_o  = (count_q == CNT_FULL);
  assign doPush  = push_i && !full_o;
  assign doPop   = pop_i && (count_q != '0);
  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;

  // Storage and pointers; storage is cleared so the head reads 0 after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (doPush) begin
        mem_q[wptr_q] <= wdata_i;
        wptr_q        <= wptr_q + PTR_ONE;
      end
      if (doPop) begin
        rptr_q <= rptr_q + PTR_ONE;
      end
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ps2_kbd_rx.sv
// ---------------------------------------------------------------------------
// ps2_kbd_rx
// PS/2 keyboard receiver: synchronises the raw pins, deserialises and checks
// 11-bit frames, buffers good scan codes in a show-ahead FIFO and tracks the
// current key and the number of key presses.
// Optional macro PS2_TIMEOUT_EN: adds TIMEOUT_CYCLES and a timer that drops
// a partial frame when the keyboard clock stalls.
// Ports:
//   clk, rst        : system clock, asynchronous active-high reset
//   ps2_clk/ps2_data: raw keyboard pins (asynchronous)
//   rd_en           : pop the FIFO head
//   data, valid     : FIFO head and non-empty flag
//   overflow        : sticky, a good frame was dropped on a full FIFO
//   frame_err       : one-cycle pulse on a bad or timed-out frame
//   key_code        : last make code accepted
//   key_down        : key_code currently held
//   press_cnt       : number of key presses, wrapping
// ---------------------------------------------------------------------------
module ps2_kbd_rx
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
`ifdef PS2_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 50000
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rd_en,
  output logic [7:0] data,
  output logic       valid,
  output logic       overflow,
  output logic       frame_err,
  output logic [7:0] key_code,
  output logic       key_down,
  output logic [7:0] press_cnt
);

  localparam logic [3:0] LAST_BIT = 4'(PS2_FRAME_BITS - 1);

  logic [2:0] clkSync_q;
  logic [2:0] dataSync_q;
  logic       fe;
  logic       dataBit;
  logic [3:0] bitCnt_q;
  logic [9:0] shift_q;
  logic [7:0] code_q;
  logic       push_q;
  logic       frameErr_q;
  logic       frameOk;
  logic       timeoutHit;

  logic                        fifoFull;
  logic [$clog2(FIFO_DEPTH):0] fifoCount;
  logic                        overflow_q;

  trackState_e state_q;
  logic [7:0]  keyCode_q;
  logic        keyDown_q;
  logic [7:0]  pressCnt_q;

  assign fe      = clkSync_q[2] & ~clkSync_q[1];
  assign dataBit = dataSync_q[2];

  // shift_q holds start in bit 0, data in 8:1, parity in bit 9; the stop
  // bit is the sample arriving with the final edge.
  assign frameOk = (shift_q[0] == 1'b0) && (^shift_q[9:1]) && dataBit;

  // Three-flop synchronisers for both raw pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clkSync_q  <= '0;
      dataSync_q <= '0;
    end else begin
      clkSync_q  <= {clkSync_q[1:0], ps2_clk};
      dataSync_q <= {dataSync_q[1:0], ps2_data};
    end
  end

`ifdef PS2_TIMEOUT_EN
  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMER_ONE = 1;

  logic [TIMER_W-1:0] timer_q;

  assign timeoutHit = (bitCnt_q != '0) && (timer_q == TIMER_MAX);

  // Idle-time counter, only running while a frame is partly received.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q <= '0;
    end else if (fe || (bitCnt_q == '0) || timeoutHit) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + TIMER_ONE;
    end
  end
`else
  assign timeoutHit = 1'b0;
`endif

  // Deserialiser: shifts bits 0..9, checks the frame on the stop bit and
  // raises either the push strobe or the error pulse for one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bitCnt_q   <= '0;
      shift_q    <= '0;
      code_q     <= '0;
      push_q     <= 1'b0;
      frameErr_q <= 1'b0;
    end else begin
      push_q     <= 1'b0;
      frameErr_q <= 1'b0;
      if (fe) begin
        if (bitCnt_q == LAST_BIT) begin
          bitCnt_q <= '0;
          if (frameOk) begin
            push_q <= 1'b1;
            code_q <= shift_q[8:1];
          end else begin
            frameErr_q <= 1'b1;
          end
        end else begin
          shift_q  <= {dataBit, shift_q[9:1]};
          bitCnt_q <= bitCnt_q + 4'd1;
        end
      end else if (timeoutHit) begin
        bitCnt_q   <= '0;
        frameErr_q <= 1'b1;
      end
    end
  end

  ps2_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (push_q),
    .pop_i  (rd_en),
    .wdata_i(code_q),
    .rdata_o(data),
    .full_o (fifoFull),
    .count_o(fifoCount)
  );

  assign valid = (fifoCount != '0);

  // Sticky overflow flag for good frames lost to a full FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else if (push_q && fifoFull) begin
      overflow_q <= 1'b1;
    end
  end

  // Make/break tracker; sees every good frame even when the FIFO drops it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      keyCode_q  <= '0;
      keyDown_q  <= 1'b0;
      pressCnt_q <= '0;
    end else if (push_q) begin
      case (state_q)
        IDLE: begin
          if (code_q == PS2_BREAK) begin
            state_q <= BREAK;
          end else if (code_q == PS2_EXT) begin
            state_q <= IDLE;
          end else if ((code_q == keyCode_q) && keyDown_q) begin
            state_q <= IDLE;
          end else begin
            keyCode_q  <= code_q;
            keyDown_q  <= 1'b1;
            pressCnt_q <= pressCnt_q + 8'd1;
          end
        end
        BREAK: begin
          state_q <= IDLE;
          if (code_q == keyCode_q) begin
            keyDown_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign overflow  = overflow_q;
  assign frame_err = frameErr_q;
  assign key_code  = keyCode_q;
  assign key_down  = keyDown_q;
  assign press_cnt = pressCnt_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// ---------------------------------------------------------------------------
// tb_ps2_kbd_rx
// Directed bench for ps2_kbd_rx. Frames are driven with 20-cycle low and
// 20-cycle high keyboard clock phases; data changes mid high phase.
// Build with PS2_TIMEOUT_EN defined to include the stalled-frame scenario.
// ---------------------------------------------------------------------------
module tb_ps2_kbd_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       rd_en = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       overflow;
  logic       frame_err;
  logic [7:0] key_code;
  logic       key_down;
  logic [7:0] press_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lastFallCyc = 0;
  int errHighCycles = 0;
  int errPulses = 0;
  int errLastCyc = 0;
  logic errPrev = 1'b0;

`ifdef PS2_TIMEOUT_EN
  ps2_kbd_rx #(.FIFO_DEPTH(8), .TIMEOUT_CYCLES(100)) dut (
`else
  ps2_kbd_rx #(.FIFO_DEPTH(8)) dut (
`endif
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .rd_en    (rd_en),
    .data     (data),
    .valid    (valid),
    .overflow (overflow),
    .frame_err(frame_err),
    .key_code (key_code),
    .key_down (key_down),
    .press_cnt(press_cnt)
  );

  // 10-unit system clock.
  always #5 clk = ~clk;

  // Cycle counter used to time the error pulse.
  always @(posedge clk) cyc <= cyc + 1;

  // Running record of frame_err activity, sampled mid-cycle.
  always @(negedge clk) begin
    if (frame_err) begin
      errHighCycles = errHighCycles + 1;
      errLastCyc = cyc;
      if (!errPrev) errPulses = errPulses + 1;
    end
    errPrev = frame_err;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks = checks + 1;
    if (actual !== expected) begin
      errors = errors + 1;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    rst = 1'b1;
    waitCycles(3);
    rst = 1'b0;
    waitCycles(2);
  endtask

  task automatic sendBit(input logic b);
    ps2_data = b;
    waitCycles(10);
    ps2_clk = 1'b0;
    lastFallCyc = cyc;
    waitCycles(20);
    ps2_clk = 1'b1;
    waitCycles(10);
  endtask

  // Sends the first nBits of a frame for code; flipPar corrupts parity.
  task automatic applyStimulus(input logic [7:0] code, input logic flipPar,
                               input int nBits);
    logic [10:0] frame;
    frame = {1'b1, (~^code) ^ flipPar, code, 1'b0};
    for (int i = 0; i < nBits; i++) begin
      sendBit(frame[i]);
    end
    ps2_data = 1'b1;
  endtask

  initial begin
    int p0;
    int h0;
    logic [7:0] expCodes [4];
    expCodes[0] = 8'h1C; expCodes[1] = 8'h1C;
    expCodes[2] = 8'hF0; expCodes[3] = 8'h1C;

    waitCycles(3);
    rst = 1'b0;
    waitCycles(2);

    // Reset state
    checkOutput("rst_data", 32'(data), 32'h0);
    checkOutput("rst_valid", 32'(valid), 32'h0);
    checkOutput("rst_overflow", 32'(overflow), 32'h0);
    checkOutput("rst_frame_err", 32'(frame_err), 32'h0);
    checkOutput("rst_key_code", 32'(key_code), 32'h0);
    checkOutput("rst_key_down", 32'(key_down), 32'h0);
    checkOutput("rst_press_cnt", 32'(press_cnt), 32'h0);

    // Scenario 1: single good frame, latency of valid from the stop-bit edge
    applyStimulus(8'h1C, 1'b0, 10);
    ps2_data = 1'b1;
    waitCycles(10);
    ps2_clk = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("s1_valid_early", 32'(valid), 32'h0);
    checkOutput("s1_no_err", 32'(frame_err), 32'h0);
    @(negedge clk);
    checkOutput("s1_valid_lat2", 32'(valid), 32'h1);
    checkOutput("s1_data", 32'(data), 32'h1C);
    checkOutput("s1_key_code", 32'(key_code), 32'h1C);
    checkOutput("s1_key_down", 32'(key_down), 32'h1);
    checkOutput("s1_press_cnt", 32'(press_cnt), 32'h1);
    @(posedge clk); #1;
    waitCycles(14);
    ps2_clk = 1'b1;
    waitCycles(10);
    rd_en = 1'b1;
    waitCycles(1);
    rd_en = 1'b0;
    checkOutput("s1_valid_after_pop", 32'(valid), 32'h0);

    // Scenario 2: typematic repeat and break
    applyReset();
    applyStimulus(8'h1C, 1'b0, 11);
    applyStimulus(8'h1C, 1'b0, 11);
    checkOutput("s2_typematic_cnt", 32'(press_cnt), 32'h1);
    applyStimulus(8'hF0, 1'b0, 11);
    checkOutput("s2_break_prefix_down", 32'(key_down), 32'h1);
    applyStimulus(8'h1C, 1'b0, 11);
    checkOutput("s2_key_down", 32'(key_down), 32'h0);
    checkOutput("s2_key_code", 32'(key_code), 32'h1C);
    checkOutput("s2_press_cnt", 32'(press_cnt), 32'h1);
    for (int i = 0; i < 4; i++) begin
      checkOutput("s2_fifo_valid", 32'(valid), 32'h1);
      checkOutput("s2_fifo_order", 32'(data), 32'(expCodes[i]));
      rd_en = 1'b1;
      waitCycles(1);
      rd_en = 1'b0;
    end
    checkOutput("s2_fifo_empty", 32'(valid), 32'h0);

    // Scenario 3: bad parity, then a good frame
    applyReset();
    p0 = errPulses;
    h0 = errHighCycles;
    applyStimulus(8'h1C, 1'b1, 11);
    checkOutput("s3_err_pulses", 32'(errPulses - p0), 32'h1);
    checkOutput("s3_err_width", 32'(errHighCycles - h0), 32'h1);
    checkOutput("s3_valid", 32'(valid), 32'h0);
    checkOutput("s3_key_code", 32'(key_code), 32'h0);
    checkOutput("s3_press_cnt", 32'(press_cnt), 32'h0);
    applyStimulus(8'h32, 1'b0, 11);
    checkOutput("s3_good_valid", 32'(valid), 32'h1);
    checkOutput("s3_good_data", 32'(data), 32'h32);
    checkOutput("s3_good_key", 32'(key_code), 32'h32);
    checkOutput("s3_good_err", 32'(errPulses - p0), 32'h1);

    // Scenario 4: overflow on the ninth frame
    applyReset();
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(8'(i), 1'b0, 11);
    end
    checkOutput("s4_full_no_ovf", 32'(overflow), 32'h0);
    applyStimulus(8'h09, 1'b0, 11);
    checkOutput("s4_overflow", 32'(overflow), 32'h1);
    checkOutput("s4_press_cnt", 32'(press_cnt), 32'h9);
    checkOutput("s4_key_code", 32'(key_code), 32'h09);
    for (int i = 1; i <= 8; i++) begin
      checkOutput("s4_drain_data", 32'(data), 32'(i));
      rd_en = 1'b1;
      waitCycles(1);
      rd_en = 1'b0;
    end
    checkOutput("s4_drained", 32'(valid), 32'h0);
    rd_en = 1'b1;
    waitCycles(1);
    rd_en = 1'b0;
    checkOutput("s4_empty_pop_valid", 32'(valid), 32'h0);
    applyStimulus(8'h2A, 1'b0, 11);
    checkOutput("s4_after_empty_pop", 32'(data), 32'h2A);
    checkOutput("s4_overflow_sticky", 32'(overflow), 32'h1);
    applyReset();
    checkOutput("s4_ovf_cleared", 32'(overflow), 32'h0);

    // Scenario 5: reset in the middle of a frame
    applyStimulus(8'h1C, 1'b0, 11);
    applyStimulus(8'h45, 1'b0, 5);
    rst = 1'b1;
    #2;
    checkOutput("s5_rst_valid", 32'(valid), 32'h0);
    checkOutput("s5_rst_data", 32'(data), 32'h0);
    checkOutput("s5_rst_key_code", 32'(key_code), 32'h0);
    checkOutput("s5_rst_key_down", 32'(key_down), 32'h0);
    checkOutput("s5_rst_press_cnt", 32'(press_cnt), 32'h0);
    waitCycles(3);
    rst = 1'b0;
    waitCycles(2);
    p0 = errPulses;
    applyStimulus(8'h45, 1'b0, 11);
    checkOutput("s5_data", 32'(data), 32'h45);
    checkOutput("s5_key_code", 32'(key_code), 32'h45);
    checkOutput("s5_press_cnt", 32'(press_cnt), 32'h1);
    checkOutput("s5_no_err", 32'(errPulses - p0), 32'h0);

`ifdef PS2_TIMEOUT_EN
    // Scenario 6: stalled partial frame is dropped by the timer
    applyReset();
    p0 = errPulses;
    h0 = errHighCycles;
    applyStimulus(8'h16, 1'b0, 4);
    waitCycles(150);
    checkOutput("s6_err_pulses", 32'(errPulses - p0), 32'h1);
    checkOutput("s6_err_width", 32'(errHighCycles - h0), 32'h1);
    checkOutput("s6_err_delay_ok",
                32'(((errLastCyc - (lastFallCyc + 2)) >= 100) &&
                    ((errLastCyc - (lastFallCyc + 2)) <= 101)), 32'h1);
    checkOutput("s6_valid", 32'(valid), 32'h0);
    applyStimulus(8'h16, 1'b0, 11);
    checkOutput("s6_data", 32'(data), 32'h16);
    checkOutput("s6_key_code", 32'(key_code), 32'h16);
    checkOutput("s6_no_extra_err", 32'(errPulses - p0), 32'h1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_kbd_rx.md
Name: ps2_kbd_rx

Overview:
- PS/2 keyboard receive stage; sits directly upstream of the seven-segment display path in the board top level.
- Takes raw board pins ps2_clk/ps2_data, deserialises and checks 11-bit frames, and buffers good scan codes in a show-ahead FIFO.
- Tracks the current key (make/break) and counts key presses; key_code/press_cnt feed the hex-to-segment decoders.

Parameters:
- FIFO_DEPTH, 8, scan-code FIFO entries; power of two, at least 2.
- TIMEOUT_CYCLES, 50000, clk cycles without a PS/2 falling edge before a partial frame is discarded (PS2_TIMEOUT_EN only).

Ports:
- clk  input  1  system clock (all logic single-domain).
- rst  input  1  asynchronous, active-high reset.
- ps2_clk  input  1  raw keyboard clock, asynchronous to clk.
- ps2_data  input  1  raw keyboard data, asynchronous to clk.
- rd_en  input  1  pop request for the FIFO head.
- data  output  8  FIFO head scan code (show-ahead).
- valid  output  1  FIFO non-empty.
- overflow  output  1  sticky: a good frame was dropped because the FIFO was full.
- frame_err  output  1  one-cycle pulse on a bad start, parity or stop bit.
- key_code  output  8  last make code accepted.
- key_down  output  1  key_code is currently held.
- press_cnt  output  8  count of distinct key presses, wraps 255->0.

Behaviour:
- Reset (async, rst=1):
  - Synchronisers, bit counter, shift register, FIFO pointers and count are cleared.
  - data, valid, overflow, frame_err, key_code, key_down and press_cnt are all 0; tracker state is IDLE.
- Synchronisers: ps2_clk passes through 3 flops and ps2_data through 3 flops. The falling edge is fe = s[2] & ~s[1]. Data is sampled from its synchronised copy in the same cycle as fe.
- Deserialiser:
  - bit_cnt runs 0..10. On each fe, bits 0..9 shift into a 10-bit register, LSB first, and bit_cnt increments.
  - At fe with bit_cnt==10, the frame is checked:
    - start bit == 0;
    - odd parity: XOR of the 8 data bits and the parity bit == 1;
    - stop bit (current sample) == 1.
  - bit_cnt returns to 0 in either case.
- Good frame:
  - push strobe asserts in the cycle after that fe.
  - valid/data reflect the pushed code on the following cycle when the FIFO was empty. Latency is 2 clk cycles from the stop-bit fe to valid.
- Bad frame: frame_err pulses for exactly 1 cycle (same cycle the push strobe would have asserted); nothing is pushed and the tracker is unaffected.
- FIFO:
  - data = mem[rptr] combinationally; valid = (count != 0).
  - rd_en with valid pops. rd_en with an empty FIFO is ignored with no pointer change.
  - Fullness is evaluated before the same-cycle pop: a push into a full FIFO is dropped even if rd_en pops in the same cycle, and overflow is set.
  - Push and pop on a non-full, non-empty FIFO in the same cycle: count is unchanged and both pointers advance.
  - Pointers wrap modulo FIFO_DEPTH.
  - overflow is cleared only by rst.
- Tracker FSM (acts on every good frame, including frames dropped by the FIFO):
  - IDLE:
    - code 0xF0 -> BREAK.
    - code 0xE0 -> ignored, stay in IDLE.
    - code == key_code with key_down=1 -> typematic repeat, no change.
    - otherwise: key_code<=code, key_down<=1, press_cnt<=press_cnt+1 (wraps).
  - BREAK:
    - any code -> IDLE.
    - if code == key_code, key_down<=0. key_code is retained.
- Reset mid-frame: the partial frame is lost. The first fe after reset release is treated as a start bit.

Optional Feature:
- Macro: PS2_TIMEOUT_EN.
- Defined: a timer counts clk cycles since the last fe while bit_cnt != 0.
  - On reaching TIMEOUT_CYCLES-1 it clears bit_cnt and pulses frame_err for 1 cycle.
  - The timer resets on every fe and whenever bit_cnt==0.
- Undefined: no timer. A partial frame waits indefinitely and is completed by later edges.

Decomposition:
- Shared package ps2_pkg:
  - constants PS2_FRAME_BITS=11, PS2_BREAK=8'hF0, PS2_EXT=8'hE0;
  - tracker state typedef {IDLE, BREAK}.
- One sub-module, ps2_fifo: parameterised FIFO_DEPTH x 8, show-ahead, push/pop/full/empty/count.
- Synchroniser, deserialiser and tracker stay in ps2_kbd_rx.

Test Plan:
- Bench drives ps2_clk with 20-cycle low and 20-cycle high phases.
- Scenario 1: send good frame 0x1C -> valid=1, data=0x1C 2 cycles after stop-bit fe; key_code=0x1C, key_down=1, press_cnt=1; rd_en 1 cycle -> valid=0.
- Scenario 2: send 0x1C, 0x1C, 0xF0, 0x1C -> press_cnt stays 1; key_down=0 after the last frame; FIFO holds 4 entries in order 1C,1C,F0,1C.
- Scenario 3: send 0x1C with wrong parity bit -> frame_err high exactly 1 cycle; valid=0; key_code unchanged; a following good 0x32 is received correctly.
- Scenario 4: 9 good frames 0x01..0x09 with no rd_en (FIFO_DEPTH=8) -> overflow=1; reading drains 0x01..0x08; overflow stays 1 until rst; press_cnt=9.
- Scenario 5: assert rst mid-frame after 5 bits -> all outputs 0 immediately; next full frame 0x45 is accepted cleanly.
- Scenario 6 (PS2_TIMEOUT_EN, TIMEOUT_CYCLES=100): send 4 bits then stop -> frame_err pulses at 100 cycles after the last fe; a following frame 0x16 is accepted.
